// File: rtl/sc_jug_pkg.sv
// sc_jug_pkg: shift codes shared with the player register and jug controller FSM states
package sc_jug_pkg;
  localparam logic [1:0] SHIFT_NONE  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FIRE = 2'b01,
    ST_HOLD = 2'b10
  } jug_state_t;
endpackage

// File: rtl/sc_sync2.sv
// sc_sync2: two-flop synchronizer with configurable reset value
module sc_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
endmodule

// File: rtl/sc_jugctrl.sv
// sc_jugctrl: one shift command per button press; auto-repeat when SC_JUGCTRL_AUTOREPEAT_EN is defined
module sc_jugctrl
  import sc_jug_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000,
  parameter int unsigned CNT_WIDTH     = 25
) (
  input  logic       SC_JUGCTRL_CLOCK_50,
  input  logic       SC_JUGCTRL_RESET_InHigh,
  input  logic       SC_JUGCTRL_left_InLow,
  input  logic       SC_JUGCTRL_right_InLow,
  output logic [1:0] SC_JUGCTRL_shiftselection_OutBUS,
  output logic       SC_JUGCTRL_holding_Out
);
  logic left_s, right_s, leave, rep;
  logic [1:0] dir, dir_q, dir_d;
  jug_state_t state_q, state_d;
  sc_sync2 #(.RST_VAL(1'b1)) u_sync_left (
    .clk(SC_JUGCTRL_CLOCK_50),
    .rst(SC_JUGCTRL_RESET_InHigh),
    .d(SC_JUGCTRL_left_InLow),
    .q(left_s)
  );
  sc_sync2 #(.RST_VAL(1'b1)) u_sync_right (
    .clk(SC_JUGCTRL_CLOCK_50),
    .rst(SC_JUGCTRL_RESET_InHigh),
    .d(SC_JUGCTRL_right_InLow),
    .q(right_s)
  );
  assign dir = (!left_s && right_s) ? SHIFT_LEFT : (left_s && !right_s) ? SHIFT_RIGHT : SHIFT_NONE;
  assign leave = state_q == ST_HOLD && dir != dir_q;
`ifdef SC_JUGCTRL_AUTOREPEAT_EN
  localparam logic [CNT_WIDTH-1:0] DLY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PER_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic first_q, first_d;
  assign rep = state_q == ST_HOLD && !leave && cnt_q == (first_q ? DLY_LAST : PER_LAST);
  assign cnt_d = state_q == ST_HOLD ? cnt_q + CNT_WIDTH'(1) : '0;
  assign first_d = leave ? 1'b1 : rep ? 1'b0 : first_q;
  always_ff @(posedge SC_JUGCTRL_CLOCK_50 or posedge SC_JUGCTRL_RESET_InHigh)
    if (SC_JUGCTRL_RESET_InHigh) begin
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
`else
  logic unused_cfg;
  assign rep = 1'b0;
  assign unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD, CNT_WIDTH};
`endif
  always_comb begin
    state_d = state_q == ST_IDLE ? (dir != SHIFT_NONE ? ST_FIRE : ST_IDLE) :
              state_q == ST_FIRE ? ST_HOLD :
              leave ? ST_IDLE : rep ? ST_FIRE : ST_HOLD;
    dir_d = (state_q == ST_IDLE && dir != SHIFT_NONE) ? dir : dir_q;
  end
  always_ff @(posedge SC_JUGCTRL_CLOCK_50 or posedge SC_JUGCTRL_RESET_InHigh)
    if (SC_JUGCTRL_RESET_InHigh) begin
      state_q <= ST_IDLE;
      dir_q   <= SHIFT_NONE;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  assign SC_JUGCTRL_shiftselection_OutBUS = state_q == ST_FIRE ? dir_q : SHIFT_NONE;
  assign SC_JUGCTRL_holding_Out = state_q == ST_HOLD;
endmodule

// File: tb/tb_sc_jugctrl.sv
// tb_sc_jugctrl: vector table, corner sequences and randomized run against a press/age reference model
module tb_sc_jugctrl;
  localparam int DLY = 8;
  localparam int PER = 4;
`ifdef SC_JUGCTRL_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  typedef struct {
    logic rs;
    logic lv;
    logic rv;
    logic [1:0] sh;
    logic ho;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic l = 1'b1;
  logic r = 1'b1;
  logic [1:0] sh;
  logic ho;
  int chk = 0;
  int err = 0;
  vec_t tbl [46];
  logic [1:0] hist [2];
  logic [1:0] mdir, m_sh;
  logic m_ho;
  int age, nrep;
  always #5 clk = ~clk;
  sc_jugctrl #(.REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .CNT_WIDTH(4)) dut (
    .SC_JUGCTRL_CLOCK_50(clk),
    .SC_JUGCTRL_RESET_InHigh(rst),
    .SC_JUGCTRL_left_InLow(l),
    .SC_JUGCTRL_right_InLow(r),
    .SC_JUGCTRL_shiftselection_OutBUS(sh),
    .SC_JUGCTRL_holding_Out(ho)
  );
  function automatic logic [1:0] decode(input logic lv, input logic rv);
    return (!lv && rv) ? 2'b01 : (lv && !rv) ? 2'b10 : 2'b00;
  endfunction
  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic set_in(input int a, input int b, input logic rs, input logic lv, input logic rv);
    for (int i = a; i <= b; i++) begin
      tbl[i].rs = rs;
      tbl[i].lv = lv;
      tbl[i].rv = rv;
      tbl[i].sh = 2'b00;
      tbl[i].ho = 1'b0;
    end
  endtask
  task automatic set_ex(input int a, input int b, input logic [1:0] s, input logic h);
    for (int i = a; i <= b; i++) begin
      tbl[i].sh = s;
      tbl[i].ho = h;
    end
  endtask
  task automatic step(input logic rs, input logic lv, input logic rv);
    rst = rs;
    l = lv;
    r = rv;
    @(negedge clk);
  endtask
  task automatic model_step();
    logic [1:0] d;
    bit fired;
    fired = 1'b0;
    if (rst) begin
      hist[0] = 2'b00;
      hist[1] = 2'b00;
      mdir = 2'b00;
      age = 0;
      nrep = 0;
    end else begin
      d = hist[1];
      hist[1] = hist[0];
      hist[0] = decode(l, r);
      if (mdir == 2'b00) begin
        if (d != 2'b00) begin
          mdir = d;
          age = 0;
          nrep = 0;
          fired = 1'b1;
        end
      end else if (age > 0 && d != mdir) begin
        mdir = 2'b00;
      end else begin
        age++;
        if (AR && age == (nrep == 0 ? DLY + 1 : PER + 1)) begin
          age = 0;
          nrep++;
          fired = 1'b1;
        end
      end
    end
    m_sh = fired ? mdir : 2'b00;
    m_ho = mdir != 2'b00 && !fired;
  endtask
  initial begin
    set_in(0, 2, 1'b1, 1'b1, 1'b1);
    set_in(3, 5, 1'b0, 1'b1, 1'b1);
    set_in(6, 10, 1'b0, 1'b0, 1'b1);
    set_in(11, 15, 1'b0, 1'b1, 1'b1);
    set_in(16, 21, 1'b0, 1'b0, 1'b0);
    set_in(22, 25, 1'b0, 1'b1, 1'b0);
    set_in(26, 29, 1'b0, 1'b1, 1'b1);
    set_in(30, 35, 1'b0, 1'b0, 1'b1);
    set_in(36, 41, 1'b0, 1'b1, 1'b0);
    set_in(42, 45, 1'b0, 1'b1, 1'b1);
    set_ex(8, 8, 2'b01, 1'b0);
    set_ex(9, 12, 2'b00, 1'b1);
    set_ex(24, 24, 2'b10, 1'b0);
    set_ex(25, 27, 2'b00, 1'b1);
    set_ex(32, 32, 2'b01, 1'b0);
    set_ex(33, 37, 2'b00, 1'b1);
    set_ex(39, 39, 2'b10, 1'b0);
    set_ex(40, 43, 2'b00, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 46; i++) begin
      step(tbl[i].rs, tbl[i].lv, tbl[i].rv);
      check($sformatf("vec%0d_shift", i), sh, tbl[i].sh);
      check($sformatf("vec%0d_hold", i), {1'b0, ho}, {1'b0, tbl[i].ho});
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b1);
      check("idle_shift", sh, 2'b00);
    end
    for (int k = 0; k < 34; k++) begin
      step(1'b0, 1'b1, k < 30 ? 1'b0 : 1'b1);
      check($sformatf("rep%0d_shift", k), sh,
            (k == 2 || (AR && k >= 11 && k <= 31 && (k - 11) % 5 == 0)) ? 2'b10 : 2'b00);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b1);
    check("pre_arst_hold", {1'b0, ho}, 2'b01);
    #2 rst = 1'b1;
    #1;
    check("arst_shift", sh, 2'b00);
    check("arst_hold", {1'b0, ho}, 2'b00);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1);
      check($sformatf("post_rst%0d_shift", k), sh, k == 2 ? 2'b01 : 2'b00);
      check($sformatf("post_rst%0d_hold", k), {1'b0, ho}, {1'b0, k == 3});
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    l = 1'b1;
    r = 1'b1;
    model_step();
    @(negedge clk);
    for (int i = 0; i < 1500; i++) begin
      check("rand_shift", sh, m_sh);
      check("rand_hold", {1'b0, ho}, {1'b0, m_ho});
      rst = $urandom_range(0, 199) == 0;
      if ($urandom_range(0, i < 750 ? 5 : 24) == 0) begin
        l = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
      end
      model_step();
      @(negedge clk);
    end
    check("rand_shift", sh, m_sh);
    check("rand_hold", {1'b0, ho}, {1'b0, m_ho});
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
